vga_scan_generator: RTL
=======================

VGA_SCAN_GENERATOR -- requirements
Module: vga_scan_generator

Interface
REQ-001 Parameter H_VIS, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 Parameter V_VIS, 480, visible lines per frame.
REQ-006 Parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, vertical porch and sync widths in lines.
REQ-007 Port iVGA_CLK, input, 1, pixel clock (25 MHz nominal).
REQ-008 Port iRST_n, input, 1, reset; asynchronous, active-low.
REQ-009 Port iEN, input, 1, scan enable; when low, counters and all outputs hold.
REQ-010 Port oHS, output, 1, horizontal sync, active-low.
REQ-011 Port oVS, output, 1, vertical sync, active-low.
REQ-012 Port oBLANK_n, output, 1, high only during visible pixels.
REQ-013 Port oADDR, output, 19, linear pixel address for index memory read.
REQ-014 Port oX, output, 10, current column; port oY, output, 9, current row.
REQ-015 Port oFRAME_START, output, 1, single-cycle pulse on the first visible pixel of a frame.
REQ-016 Port oVBLANK, output, 1, high while the vertical count is at or beyond V_VIS (safe window for index writes).
REQ-017 Port oFRAME_CNT, output, 8, frame counter.

Function
REQ-018 Internal counter h_cnt SHALL count 0 .. H_TOT-1, where H_TOT = sum of all H parameters (800), then wrap to 0.
REQ-019 Internal counter v_cnt SHALL advance on each h_cnt wrap and count 0 .. V_TOT-1, where V_TOT = sum of all V parameters (525), then wrap to 0.
REQ-020 The visible region SHALL be h_cnt < H_VIS and v_cnt < V_VIS.
REQ-021 The horizontal sync region SHALL be H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751).
REQ-022 The vertical sync region SHALL be V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491).
REQ-023 All outputs SHALL be registered and reflect the counter state of the previous enabled cycle (fixed latency of 1 clock).
REQ-024 oX and oY SHALL equal h_cnt and v_cnt during visible pixels and hold their last visible value otherwise.
REQ-025 oADDR SHALL equal oY*640+oX during visible pixels, built from an incrementing counter with no multiplier.
REQ-026 oADDR SHALL reset to 0 when v_cnt = V_TOT-1 and h_cnt = H_TOT-1, SHALL hold during blanking, and SHALL never exceed 307199.
REQ-027 oFRAME_START SHALL be high exactly when the registered position is (0,0).
REQ-028 oFRAME_CNT SHALL increment by 1 with each oFRAME_START pulse and wrap from 255 to 0.
REQ-029 When iEN is deasserted mid-line, the scan SHALL hold its position; on re-enable it SHALL resume from that same position with no skipped or repeated address.
REQ-030 Arithmetic SHALL be unsigned; counter widths SHALL be 10 bits (h_cnt) and 10 bits (v_cnt).

Reset
REQ-031 On iRST_n low, h_cnt, v_cnt, oADDR, oX, oY and oFRAME_CNT SHALL become 0 immediately.
REQ-032 On iRST_n low, oHS and oVS SHALL become 1, and oBLANK_n, oFRAME_START and oVBLANK SHALL become 0.
REQ-033 A reset asserted mid-frame SHALL abort the frame; after release, the first enabled edge SHALL begin the scan at (0,0).

Structure
REQ-034 The timing constants and the derived H_TOT and V_TOT SHALL reside in the shared package vga_timing_pkg.
REQ-035 A single sub-module, scan_counter (parameterised wrap counter with enable and carry-out), SHALL be instantiated once for h_cnt and once for v_cnt.

Verification
REQ-036 Reset release with iEN=1 for 420000 clocks -> oHS low for 96 clocks every 800, oVS low for 1600 clocks every 420000, and oFRAME_START pulses at clocks 1 and 420001.
REQ-037 Count oBLANK_n-high cycles over one frame -> exactly 307200, with oADDR sequencing 0..307199 with no gaps.
REQ-038 At h_cnt=639 and v_cnt=479 -> oADDR=307199, oX=639, oY=479; on the next cycle oBLANK_n=0 and oVBLANK=1 from line 480.
REQ-039 Deassert iEN for 50 clocks at oADDR=1000 -> all outputs frozen; after re-enable the next oADDR is 1001.
REQ-040 Assert iRST_n low at v_cnt=200 -> all outputs reach reset values asynchronously; oFRAME_CNT returns to 0 and the scan restarts at (0,0).
REQ-041 Run 256 frames -> oFRAME_CNT wraps from 255 to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing: 640x480@60 defaults, derived totals and small helpers
// used by the scan generator and its counters.
package vga_timing_pkg;
  localparam int unsigned H_VIS_DEF  = 640;
  localparam int unsigned H_FP_DEF   = 16;
  localparam int unsigned H_SYNC_DEF = 96;
  localparam int unsigned H_BP_DEF   = 48;
  localparam int unsigned V_VIS_DEF  = 480;
  localparam int unsigned V_FP_DEF   = 10;
  localparam int unsigned V_SYNC_DEF = 2;
  localparam int unsigned V_BP_DEF   = 33;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned FC_W   = 8;

  function automatic int unsigned sum4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    return a + b + c + d;
  endfunction

  localparam int unsigned H_TOT = sum4(H_VIS_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOT = sum4(V_VIS_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // lo <= c < hi, constants narrowed to the counter width
  function automatic logic in_range(input logic [CNT_W-1:0] c,
                                    input int unsigned lo, input int unsigned hi);
    return (c >= CNT_W'(lo)) && (c < CNT_W'(hi));
  endfunction
endpackage

// File: rtl/scan_counter.sv
// Wrap counter 0..TOT-1 with enable; wrap_o flags the enabled terminal count,
// i.e. the cycle on which the counter returns to zero.
module scan_counter #(
  parameter int unsigned W   = 10,
  parameter int unsigned TOT = 800
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == W'(TOT - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = wrap_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/vga_scan_generator.sv
// VGA raster scan: h/v counters plus registered sync, blank, position and
// linear read address; every output lags the counters by one enabled clock.
module vga_scan_generator import vga_timing_pkg::*; #(
  parameter int unsigned H_VIS  = H_VIS_DEF,
  parameter int unsigned H_FP   = H_FP_DEF,
  parameter int unsigned H_SYNC = H_SYNC_DEF,
  parameter int unsigned H_BP   = H_BP_DEF,
  parameter int unsigned V_VIS  = V_VIS_DEF,
  parameter int unsigned V_FP   = V_FP_DEF,
  parameter int unsigned V_SYNC = V_SYNC_DEF,
  parameter int unsigned V_BP   = V_BP_DEF
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iEN,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [ADDR_W-1:0] oADDR,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic              oFRAME_START,
  output logic              oVBLANK,
  output logic [FC_W-1:0]   oFRAME_CNT
);
  localparam int unsigned HT = sum4(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned VT = sum4(V_VIS, V_FP, V_SYNC, V_BP);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;

  scan_counter #(.W(CNT_W), .TOT(HT)) u_h (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .en_i(iEN),
    .cnt_o(h_cnt), .wrap_o(h_wrap));

  scan_counter #(.W(CNT_W), .TOT(VT)) u_v (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .en_i(h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap));

  logic vis, hsync, vsync, origin;
  assign vis    = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
  assign hsync  = in_range(h_cnt, H_VIS + H_FP, H_VIS + H_FP + H_SYNC);
  assign vsync  = in_range(v_cnt, V_VIS + V_FP, V_VIS + V_FP + V_SYNC);
  assign origin = (h_cnt == '0) && (v_cnt == '0);

  logic              hs_q, vs_q, blank_q, fs_q, vblank_q;
  logic              hs_d, vs_d, blank_d, fs_d, vblank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [FC_W-1:0]   fc_q, fc_d;

  always_comb begin
    hs_d     = hs_q;
    vs_d     = vs_q;
    blank_d  = blank_q;
    fs_d     = fs_q;
    vblank_d = vblank_q;
    addr_d   = addr_q;
    x_d      = x_q;
    y_d      = y_q;
    fc_d     = fc_q;
    if (iEN) begin
      hs_d     = ~hsync;
      vs_d     = ~vsync;
      blank_d  = vis;
      fs_d     = origin;
      vblank_d = (v_cnt >= CNT_W'(V_VIS));
      if (vis) begin
        x_d = h_cnt;
        y_d = v_cnt[Y_W-1:0];
      end
      // address is zeroed on the last clock of the frame so pixel (0,0) reads 0
      if (v_wrap)              addr_d = '0;
      else if (vis && !origin) addr_d = addr_q + ADDR_W'(1);
      // count moves on the same clock the frame-start pulse is registered
      if (origin) fc_d = fc_q + FC_W'(1);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n)
    if (!iRST_n) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      fs_q     <= 1'b0;
      vblank_q <= 1'b0;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fc_q     <= '0;
    end else begin
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      fs_q     <= fs_d;
      vblank_q <= vblank_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fc_q     <= fc_d;
    end

  assign oHS          = hs_q;
  assign oVS          = vs_q;
  assign oBLANK_n     = blank_q;
  assign oFRAME_START = fs_q;
  assign oVBLANK      = vblank_q;
  assign oADDR        = addr_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oFRAME_CNT   = fc_q;
endmodule
